// File: rtl/seq_sub32.sv
// Multi-cycle A - B - Bin, one SLICE_W slice per clock with a registered borrow; result valid NUM_SLICES cycles after accept.
// Result and flags are held while out_valid && !out_ready; in_ready stays low until the result is taken.
module seq_sub32 #(
   parameter int WIDTH   = 32,
   parameter int SLICE_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Diff,
   output logic             Bout,
   output logic             Ovf,
   output logic             Zero
);

   localparam int NUM_SLICES = WIDTH / SLICE_W;
   localparam int CNT_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

   generate
      if (WIDTH % SLICE_W != 0) begin : g_bad_width
         $error("seq_sub32: WIDTH must be a multiple of SLICE_W");
      end
      if (SLICE_W < 4 || SLICE_W > WIDTH) begin : g_bad_slice
         $error("seq_sub32: SLICE_W out of range 4..WIDTH");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, b_q;
   logic               borrow_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [SLICE_W-1:0] a_sl, b_sl, d_sl;
   logic               c_sl;
   logic [WIDTH-1:0]   diff_nxt;
   logic               last_sl;
   logic               accept;

   assign in_ready  = (state_q == IDLE) && !rst;
   assign out_valid = (state_q == DONE);
   assign accept    = in_valid && in_ready;
   assign last_sl   = (cnt_q == CNT_W'(NUM_SLICES - 1));

   // Slice datapath: pick the active slice, subtract as A + ~B + !borrow.
   always_comb begin
      a_sl     = '0;
      b_sl     = '0;
      diff_nxt = Diff;
      for (int i = 0; i < NUM_SLICES; i++) begin
         if (cnt_q == CNT_W'(i)) begin
            a_sl = a_q[i*SLICE_W +: SLICE_W];
            b_sl = b_q[i*SLICE_W +: SLICE_W];
         end
      end
      {c_sl, d_sl} = {1'b0, a_sl} + {1'b0, ~b_sl} + {{SLICE_W{1'b0}}, ~borrow_q};
      for (int i = 0; i < NUM_SLICES; i++) begin
         if (cnt_q == CNT_W'(i)) begin
            diff_nxt[i*SLICE_W +: SLICE_W] = d_sl;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept)    state_d = BUSY;
         BUSY:    if (last_sl)   state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default:                state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         borrow_q <= 1'b0;
         cnt_q    <= '0;
         Diff     <= '0;
         Bout     <= 1'b0;
         Ovf      <= 1'b0;
         Zero     <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            a_q      <= A;
            b_q      <= B;
            borrow_q <= Bin;
            cnt_q    <= '0;
         end
         if (state_q == BUSY) begin
            Diff     <= diff_nxt;
            borrow_q <= ~c_sl;
            cnt_q    <= cnt_q + CNT_W'(1);
            // Flags come from the completed difference and the latched operands.
            if (last_sl) begin
               Bout <= ~c_sl;
               Ovf  <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_nxt[WIDTH-1] != a_q[WIDTH-1]);
               Zero <= (diff_nxt == '0);
            end
         end
      end
   end

endmodule

// File: tb/tb_seq_sub32.sv
// Bench for seq_sub32: directed vectors with literal expectations plus a per-cycle
// arithmetic reference that tracks accept, latency, hold and reset behaviour.
module tb_seq_sub32;

   localparam int WIDTH      = 32;
   localparam int SLICE_W    = 16;
   localparam int NUM_SLICES = WIDTH / SLICE_W;

   typedef struct packed {
      logic [31:0] diff;
      logic        bout;
      logic        ovf;
      logic        zero;
   } res_t;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, Bin, out_valid, out_ready, Bout, Ovf, Zero;
   logic [31:0] A, B, Diff;

   int vecs = 0;
   int errs = 0;

   always #5 clk = ~clk;

   seq_sub32 #(.WIDTH(WIDTH), .SLICE_W(SLICE_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .Bin(Bin), .out_valid(out_valid), .out_ready(out_ready),
      .Diff(Diff), .Bout(Bout), .Ovf(Ovf), .Zero(Zero)
   );

   task automatic check1(input string name, input logic act, input logic exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: exact 33-bit unsigned and 64-bit signed arithmetic.
   function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic bin);
      res_t        r;
      logic [32:0] f;
      longint      s;
      f      = {1'b0, a} - {1'b0, b} - {32'b0, bin};
      s      = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
      r.diff = f[31:0];
      r.bout = f[32];
      r.ovf  = (s != longint'($signed(f[31:0])));
      r.zero = (f[31:0] == 32'h0);
      return r;
   endfunction

   logic chk_en  = 1'b0;
   logic pend    = 1'b0;
   logic saw_rst = 1'b0;
   int   wait_cnt = 0;
   res_t exp_r;

   always @(negedge clk) begin : compare
      logic was_valid;
      was_valid = 1'b0;
      if (chk_en) begin
         if (saw_rst) begin
            check1("rst_out_valid", out_valid, 1'b0);
            check32("rst_diff", Diff, 32'h0);
            check32("rst_flags", {29'b0, Bout, Ovf, Zero}, 32'h0);
         end else if (pend) begin
            check1("busy_in_ready", in_ready, 1'b0);
            if (wait_cnt > 0) begin
               check1("early_out_valid", out_valid, 1'b0);
               wait_cnt--;
            end else begin
               was_valid = 1'b1;
               check1("out_valid", out_valid, 1'b1);
               check32("model_diff", Diff, exp_r.diff);
               check32("model_flags", {29'b0, Bout, Ovf, Zero},
                       {29'b0, exp_r.bout, exp_r.ovf, exp_r.zero});
            end
         end else begin
            check1("idle_out_valid", out_valid, 1'b0);
            if (!rst) check1("idle_in_ready", in_ready, 1'b1);
         end
         if (rst) check1("rst_in_ready", in_ready, 1'b0);

         saw_rst = rst;
         if (rst) begin
            pend = 1'b0;
         end else if (was_valid && out_ready) begin
            pend = 1'b0;
         end else if (!pend && in_valid && in_ready) begin
            pend     = 1'b1;
            wait_cnt = NUM_SLICES;
            exp_r    = model(A, B, Bin);
         end
      end
   end

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic bin,
                         input logic [31:0] ed, input logic eb, input logic eo, input logic ez,
                         input int hold);
      int n;
      @(posedge clk); #1;
      out_ready = (hold == 0);
      A = a; B = b; Bin = bin; in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         vecs++; errs++;
         $display("FAIL accept_timeout: in_ready stayed %b, expected 1", in_ready);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      in_valid = 1'b0; A = 32'hDEAD_BEEF; B = ~a; Bin = ~bin;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n <= 20);
      if (!out_valid) begin
         vecs++; errs++;
         $display("FAIL result_timeout: out_valid stayed %b, expected 1", out_valid);
         return;
      end
      check32("latency", 32'(n - 1), 32'(NUM_SLICES));
      check32("lit_diff", Diff, ed);
      check32("lit_flags", {29'b0, Bout, Ovf, Zero}, {29'b0, eb, eo, ez});
      if (hold > 0) begin
         repeat (hold) begin
            @(posedge clk); #1;
            in_valid = 1'b1; A = $urandom(); B = $urandom(); Bin = 1'b1;
         end
         @(negedge clk);
         check32("hold_diff", Diff, ed);
         check32("hold_flags", {29'b0, Bout, Ovf, Zero}, {29'b0, eb, eo, ez});
         check1("hold_in_ready", in_ready, 1'b0);
         @(posedge clk); #1;
         in_valid = 1'b0; out_ready = 1'b1;
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
      @(negedge clk);
      check1("post_in_ready", in_ready, 1'b1);
      check1("post_out_valid", out_valid, 1'b0);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      res_t r;
      logic [31:0] ra, rb;
      logic        rbin;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; Bin = 1'b0;
      @(posedge clk);
      chk_en = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check1("reset_out_valid", out_valid, 1'b0);
      check32("reset_diff", Diff, 32'h0);
      check1("reset_in_ready", in_ready, 1'b1);

      run_op(32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 0);
      run_op(32'h0001_0000, 32'h0000_0001, 1'b0, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0, 0);
      run_op(32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 0);
      run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 0);
      run_op(32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 0);
      run_op(32'h1234_5678, 32'h1234_5678, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 0);
      run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 0);
      run_op(32'h0001_0000, 32'h0000_FFFF, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 0);
      run_op(32'hABCD_0000, 32'h0000_1234, 1'b1, 32'hABCC_EDCB, 1'b0, 1'b0, 1'b0, 5);

      // Abort an operation after its first slice.
      @(posedge clk); #1;
      A = 32'h0001_0000; B = 32'h0000_0001; Bin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check1("abort_out_valid", out_valid, 1'b0);
      check32("abort_diff", Diff, 32'h0);
      check1("abort_in_ready", in_ready, 1'b1);
      run_op(32'h0000_0010, 32'h0000_0001, 1'b0, 32'h0000_000F, 1'b0, 1'b0, 1'b0, 0);

      for (int k = 0; k < 6; k++) begin
         ra   = $urandom();
         rb   = (k % 2 == 0) ? $urandom() : ra;
         rbin = 1'($urandom_range(0, 1));
         r    = model(ra, rb, rbin);
         run_op(ra, rb, rbin, r.diff, r.bout, r.ovf, r.zero, k % 3);
      end

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/seq_sub32.md
Name: seq_sub32

Overview:
- Multi-cycle 32-bit subtractor: Diff = A - B - Bin, with borrow-out, signed overflow and zero flags.
- Inverse operation of the team's 32-bit block carry-lookahead adder.
- Evaluates one SLICE_W-bit slice per clock, rippling a registered borrow between slices, to cut the long carry path.
- Sits behind a valid/ready operand interface and drives a valid/ready result interface into the datapath.

Parameters:
- WIDTH, 32, operand/result width; must be an integer multiple of SLICE_W.
- SLICE_W, 16, bits evaluated per cycle; legal range 4..WIDTH.
- NUM_SLICES, WIDTH/SLICE_W, derived (localparam); cycles spent in BUSY.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- A  input  WIDTH  minuend.
- B  input  WIDTH  subtrahend.
- Bin  input  1  borrow-in.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- Diff  output  WIDTH  A - B - Bin mod 2^WIDTH.
- Bout  output  1  unsigned borrow-out (1 when A < B + Bin).
- Ovf  output  1  two's-complement overflow.
- Zero  output  1  Diff == 0.

Behaviour:
- Clocking and reset:
  - One clock domain.
  - Reset is synchronous and active-high on rst, sampled on the rising edge of clk.
  - While rst is high, in_ready = 0.
  - Reset values: state = IDLE, out_valid = 0, Diff = 0, Bout = 0, Ovf = 0, Zero = 0, slice counter = 0, borrow register = 0, operand registers = 0.
- State IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: latch A, B, Bin; borrow register <= Bin; counter <= 0; go to BUSY.
- State BUSY:
  - in_ready = 0.
  - Each cycle, slice i = counter: {c, d} = A_i + ~B_i + !borrow.
  - Diff slice i <= d; borrow <= !c; counter++.
  - After slice NUM_SLICES-1, go to DONE.
- State DONE:
  - out_valid = 1, in_ready = 0.
  - Bout = final borrow.
  - Ovf = (A[W-1] != B[W-1]) && (Diff[W-1] != A[W-1]), using the latched A and B.
  - Zero = (Diff == 0).
  - Flags are registered on entry to DONE, not computed from live inputs.
  - On out_ready: go to IDLE, out_valid <= 0.
- Latency and throughput:
  - Accept at edge k → out_valid high after edge k + NUM_SLICES (2 cycles at default).
  - Minimum issue interval NUM_SLICES + 2 cycles; operations never overlap.
- Output stability:
  - While out_valid && !out_ready, Diff/Bout/Ovf/Zero hold stable.
  - Diff/flags retain their last value after handshake until overwritten by the next operation's slice writes; they are meaningful only when out_valid = 1.
- Input side:
  - Input changes while in_ready = 0 are ignored.
  - in_valid without in_ready has no effect.
- Edge cases:
  - Borrow crossing a slice boundary is exact (registered borrow, not recomputed).
  - Bin = 1 with A = B gives all-ones, Bout = 1.
  - Reset mid-operation (BUSY or DONE): next cycle IDLE, out_valid = 0, no result emitted for the aborted operation.
- Parameter check: WIDTH % SLICE_W != 0 is an elaboration error.

Test Plan:
1. A=0x0000_0005, B=0x0000_0003, Bin=0 → Diff=0x0000_0002, Bout=0, Ovf=0, Zero=0; out_valid exactly 2 cycles after accept.
2. A=0x0001_0000, B=0x0000_0001, Bin=0 (borrow crosses slice) → Diff=0x0000_FFFF, Bout=0, Ovf=0.
3. A=0x0000_0000, B=0x0000_0001, Bin=0 → Diff=0xFFFF_FFFF, Bout=1, Ovf=0; A=0x8000_0000, B=0x0000_0001 → Diff=0x7FFF_FFFF, Ovf=1, Bout=0.
4. A=B=0x1234_5678: Bin=0 → Diff=0, Zero=1, Bout=0; Bin=1 → Diff=0xFFFF_FFFF, Bout=1, Zero=0.
5. Backpressure: out_ready held 0 for 5 cycles after out_valid → Diff/flags constant, in_ready=0, new in_valid ignored; out_ready=1 → IDLE next cycle, in_ready=1.
6. rst pulsed while in BUSY after slice 0 → next cycle out_valid=0, all outputs 0; after release in_ready=1, and a fresh op (A=0x10, B=0x1) yields Diff=0x0F.
